// File: rtl/audio_frac_clk_gen.sv
// Fractional-N clock-enable generator for the audio path.
// A phase accumulator on refclk produces the MCLK enable. A divider chain
// derives the BCLK/LRCLK enables and their 50% duty levels. Lock is reported
// once the ratio has run for LOCK_CYCLES MCLK periods.
module audio_frac_clk_gen #(
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned DEFAULT_INC = 1055531162,
  parameter int unsigned BCLK_DIV    = 4,
  parameter int unsigned LRCLK_DIV   = 64,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             enable,
  input  logic [ACC_W-1:0] inc_in,
  input  logic             inc_load,
  output logic             mclk_en,
  output logic             bclk_en,
  output logic             lrclk_en,
  output logic             bclk_o,
  output logic             lrclk_o,
  output logic             locked,
  output logic             inc_err
);

  localparam int unsigned BCLK_W   = $clog2(BCLK_DIV);
  localparam int unsigned LR_W     = $clog2(LRCLK_DIV);
  localparam int unsigned SETTLE_W = $clog2(LOCK_CYCLES + 1);

  localparam logic [ACC_W-1:0]    INC_MAX     = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [BCLK_W-1:0]   BCLK_LAST   = BCLK_W'(BCLK_DIV - 1);
  localparam logic [BCLK_W-1:0]   BCLK_HALF   = BCLK_W'(BCLK_DIV / 2);
  localparam logic [LR_W-1:0]     LR_LAST     = LR_W'(LRCLK_DIV - 1);
  localparam logic [LR_W-1:0]     LR_HALF     = LR_W'(LRCLK_DIV / 2);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t              state;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    inc;
  logic [BCLK_W-1:0]   bclk_cnt;
  logic [LR_W-1:0]     lr_cnt;
  logic [SETTLE_W-1:0] settle_cnt;

  logic [ACC_W:0]      sum_c;
  logic                inc_ok_c;
  logic                bclk_wrap_c;
  logic                lr_wrap_c;
  logic [BCLK_W-1:0]   bclk_next_c;
  logic [LR_W-1:0]     lr_next_c;

  // Next accumulator value with carry, load validity and divider next counts.
  always_comb begin
    sum_c       = {1'b0, acc} + {1'b0, inc};
    inc_ok_c    = (inc_in != '0) && (inc_in <= INC_MAX);
    bclk_wrap_c = (bclk_cnt == BCLK_LAST);
    lr_wrap_c   = (lr_cnt == LR_LAST);
    bclk_next_c = bclk_wrap_c ? '0 : bclk_cnt + BCLK_W'(1);
    lr_next_c   = lr_cnt;
    if (bclk_wrap_c) begin
      lr_next_c = lr_wrap_c ? '0 : lr_cnt + LR_W'(1);
    end
  end

  // Control FSM, phase accumulator, divider chain and registered outputs.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      inc        <= ACC_W'(DEFAULT_INC);
      bclk_cnt   <= '0;
      lr_cnt     <= '0;
      settle_cnt <= '0;
      mclk_en    <= 1'b0;
      bclk_en    <= 1'b0;
      lrclk_en   <= 1'b0;
      bclk_o     <= 1'b0;
      lrclk_o    <= 1'b0;
      locked     <= 1'b0;
      inc_err    <= 1'b0;
    end else begin
      if (inc_load) begin
        if (inc_ok_c) begin
          inc     <= inc_in;
          inc_err <= 1'b0;
        end else begin
          inc_err <= 1'b1;
        end
      end

      // Halt, start-up from IDLE and an accepted ratio change all restart from zero.
      if (!enable || (state == IDLE) || (inc_load && inc_ok_c)) begin
        state      <= enable ? SETTLE : IDLE;
        acc        <= '0;
        bclk_cnt   <= '0;
        lr_cnt     <= '0;
        settle_cnt <= '0;
        mclk_en    <= 1'b0;
        bclk_en    <= 1'b0;
        lrclk_en   <= 1'b0;
        bclk_o     <= 1'b0;
        lrclk_o    <= 1'b0;
        locked     <= 1'b0;
      end else begin
        acc     <= sum_c[ACC_W-1:0];
        mclk_en <= sum_c[ACC_W];
        if (sum_c[ACC_W]) begin
          bclk_cnt <= bclk_next_c;
          lr_cnt   <= lr_next_c;
          bclk_en  <= bclk_wrap_c;
          lrclk_en <= bclk_wrap_c && lr_wrap_c;
          bclk_o   <= (bclk_next_c >= BCLK_HALF);
          lrclk_o  <= (lr_next_c >= LR_HALF);
        end else begin
          bclk_en  <= 1'b0;
          lrclk_en <= 1'b0;
        end
        case (state)
          SETTLE: begin
            if (mclk_en) begin
              if (settle_cnt == SETTLE_LAST) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end else begin
                settle_cnt <= settle_cnt + SETTLE_W'(1);
              end
            end
          end
          LOCKED:  locked <= 1'b1;
          default: state  <= IDLE;
        endcase
      end
    end
  end

endmodule
